// File: rtl/costas_ctrl_pkg.sv
// Shared types and helpers for the Costas acquisition controller and its lock metric.
package costas_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StLoad   = 3'd1,
    StSettle = 3'd2,
    StAcq    = 3'd3,
    StTrack  = 3'd4
  } state_e;

  localparam int unsigned ArmW       = 14;
  localparam int unsigned DiffW      = 15;
  localparam int unsigned WinLog2Def = 8;
  localparam int unsigned MetricWDef = DiffW + WinLog2Def;

  function automatic int unsigned metric_w(input int unsigned win_log2);
    return DiffW + win_log2;
  endfunction

  // |x| with the single unrepresentable case (-8192) clamped to +8191.
  function automatic logic [ArmW-1:0] abs_sat(input logic signed [ArmW-1:0] x);
    if (x[ArmW-1] && (x[ArmW-2:0] == '0)) return {1'b0, {(ArmW-1){1'b1}}};
    return x[ArmW-1] ? -x : x;
  endfunction

endpackage

// File: rtl/costas_acq_ctrl_if.sv
// Control/sample bundle between the Costas loop and its acquisition sequencer.
interface costas_acq_ctrl_if #(
  parameter int unsigned FW = 32
) ();
  logic                 en;
  logic                 smp_valid;
  logic signed [13:0]   i_arm;
  logic signed [13:0]   q_arm;
  logic [FW-1:0]        freq_word;
  logic                 freq_load;
  logic                 loop_rst;
  logic                 gain_sel;
  logic                 locked;
  logic [5:0]           sweep_idx;
  logic [2:0]           state_o;

  modport master (
    output en, smp_valid, i_arm, q_arm,
    input  freq_word, freq_load, loop_rst, gain_sel, locked, sweep_idx, state_o
  );

  modport slave (
    input  en, smp_valid, i_arm, q_arm,
    output freq_word, freq_load, loop_rst, gain_sel, locked, sweep_idx, state_o
  );
endinterface

// File: rtl/costas_lock_metric.sv
// Windowed sum of |I|-|Q| over 2**WIN_LOG2 valid samples with a signed threshold compare.
module costas_lock_metric
  import costas_ctrl_pkg::*;
#(
  parameter int unsigned WIN_LOG2 = 8,
  parameter int          LOCK_THR = 262144
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_clr,
  input  logic                    i_smp_valid,
  input  logic signed [ArmW-1:0]  i_i_arm,
  input  logic signed [ArmW-1:0]  i_q_arm,
  output logic                    o_win_done,
  output logic                    o_win_pass
);

  localparam int unsigned AccW = metric_w(WIN_LOG2);
  localparam logic signed [AccW-1:0] Thr = AccW'(LOCK_THR);

  logic signed [DiffW-1:0] w_d;
  logic signed [AccW-1:0]  w_sum;
  logic signed [AccW-1:0]  r_acc;
  logic [WIN_LOG2-1:0]     r_cnt;
  logic                    r_done;
  logic                    r_pass;

  assign w_d   = signed'({1'b0, abs_sat(i_i_arm)}) - signed'({1'b0, abs_sat(i_q_arm)});
  assign w_sum = r_acc + AccW'(w_d);

  // The last sample of a window is folded into the compare directly, so the
  // accumulator restarts at zero and back-to-back windows need no gap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc  <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
      r_pass <= 1'b0;
    end else if (i_clr) begin
      r_acc  <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
      r_pass <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_pass <= 1'b0;
      if (i_smp_valid) begin
        r_cnt <= r_cnt + WIN_LOG2'(1);
        if (&r_cnt) begin
          r_acc  <= '0;
          r_done <= 1'b1;
          r_pass <= (w_sum > Thr);
        end else begin
          r_acc <= w_sum;
        end
      end
    end
  end

  assign o_win_done = r_done;
  assign o_win_pass = r_pass;

endmodule

// File: rtl/costas_acq_ctrl.sv
// Costas loop acquisition/tracking sequencer: frequency sweep, loop reset, gain select, lock.
module costas_acq_ctrl
  import costas_ctrl_pkg::*;
#(
  parameter int unsigned   FW         = 32,
  parameter logic [FW-1:0] F_START    = 32'h0A3D_70A4,
  parameter logic [FW-1:0] F_STEP     = 32'h0006_8DB9,
  parameter int unsigned   N_STEPS    = 32,
  parameter int unsigned   RST_CYC    = 16,
  parameter int unsigned   SETTLE_SMP = 1024,
  parameter int unsigned   WIN_LOG2   = 8,
  parameter int            LOCK_THR   = 262144,
  parameter int unsigned   LOCK_CNT   = 4,
  parameter int unsigned   LOSS_CNT   = 8,
  parameter int unsigned   ACQ_WIN    = 16
) (
  input logic              clk,
  input logic              rst,
  costas_acq_ctrl_if.slave bus
);

  state_e        r_state, w_state_d;
  logic [15:0]   r_cnt, w_cnt_d;
  logic [7:0]    r_win_cnt, w_win_cnt_d;
  logic [7:0]    r_pass_cnt, w_pass_cnt_d;
  logic [7:0]    r_fail_cnt, w_fail_cnt_d;
  logic          w_advance;
  logic          w_clr;
  logic          w_win_done;
  logic          w_win_pass;
  logic [FW-1:0] r_freq_word;
  logic [5:0]    r_sweep_idx;
  logic          r_freq_load;
  logic          r_loop_rst;
  logic          r_gain_sel;
  logic          r_locked;

  // Any state change discards a partial window.
  assign w_clr = ((r_state != StAcq) && (r_state != StTrack)) || (w_state_d != r_state);

  costas_lock_metric #(
    .WIN_LOG2 (WIN_LOG2),
    .LOCK_THR (LOCK_THR)
  ) u_metric (
    .clk         (clk),
    .rst         (rst),
    .i_clr       (w_clr),
    .i_smp_valid (bus.smp_valid),
    .i_i_arm     (bus.i_arm),
    .i_q_arm     (bus.q_arm),
    .o_win_done  (w_win_done),
    .o_win_pass  (w_win_pass)
  );

  always_comb begin
    w_state_d    = r_state;
    w_cnt_d      = r_cnt;
    w_win_cnt_d  = r_win_cnt;
    w_pass_cnt_d = r_pass_cnt;
    w_fail_cnt_d = r_fail_cnt;
    w_advance    = 1'b0;
    unique case (r_state)
      StIdle: if (bus.en) w_state_d = StLoad;
      StLoad: begin
        w_cnt_d = r_cnt + 16'd1;
        if (r_cnt == 16'(RST_CYC - 1)) w_state_d = StSettle;
      end
      StSettle: if (bus.smp_valid) begin
        w_cnt_d = r_cnt + 16'd1;
        if (r_cnt == 16'(SETTLE_SMP - 1)) w_state_d = StAcq;
      end
      StAcq: if (w_win_done) begin
        w_win_cnt_d  = r_win_cnt + 8'd1;
        w_pass_cnt_d = w_win_pass ? r_pass_cnt + 8'd1 : 8'd0;
        if (w_win_pass && (r_pass_cnt == 8'(LOCK_CNT - 1))) begin
          w_state_d = StTrack;
        end else if (r_win_cnt == 8'(ACQ_WIN - 1)) begin
          w_state_d = StLoad;
          w_advance = 1'b1;
        end
      end
      StTrack: if (w_win_done) begin
        if (w_win_pass) begin
          w_fail_cnt_d = 8'd0;
        end else begin
          w_fail_cnt_d = r_fail_cnt + 8'd1;
          if (r_fail_cnt == 8'(LOSS_CNT - 1)) w_state_d = StLoad;
        end
      end
      default: w_state_d = StIdle;
    endcase
    if (!bus.en) begin
      w_state_d = StIdle;
      w_advance = 1'b0;
    end
    if (w_state_d != r_state) begin
      w_cnt_d      = '0;
      w_win_cnt_d  = '0;
      w_pass_cnt_d = '0;
      w_fail_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_win_cnt   <= '0;
      r_pass_cnt  <= '0;
      r_fail_cnt  <= '0;
      r_freq_word <= F_START;
      r_sweep_idx <= '0;
      r_freq_load <= 1'b0;
      r_loop_rst  <= 1'b1;
      r_gain_sel  <= 1'b0;
      r_locked    <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_cnt       <= w_cnt_d;
      r_win_cnt   <= w_win_cnt_d;
      r_pass_cnt  <= w_pass_cnt_d;
      r_fail_cnt  <= w_fail_cnt_d;
      r_freq_load <= (w_state_d == StLoad) && (r_state != StLoad);
      r_loop_rst  <= (w_state_d == StIdle) || (w_state_d == StLoad);
      r_gain_sel  <= (w_state_d == StTrack);
      r_locked    <= (w_state_d == StTrack);
      if (w_advance) begin
        if (r_sweep_idx == 6'(N_STEPS - 1)) begin
          r_sweep_idx <= '0;
          r_freq_word <= F_START;
        end else begin
          r_sweep_idx <= r_sweep_idx + 6'd1;
          r_freq_word <= r_freq_word + F_STEP;
        end
      end
    end
  end

  assign bus.freq_word = r_freq_word;
  assign bus.freq_load = r_freq_load;
  assign bus.loop_rst  = r_loop_rst;
  assign bus.gain_sel  = r_gain_sel;
  assign bus.locked    = r_locked;
  assign bus.sweep_idx = r_sweep_idx;
  assign bus.state_o   = r_state;

endmodule

// File: tb/tb_costas_acq_ctrl.sv
// Scoreboard bench: stimulus queues expected output events, a negedge monitor checks them.
module tb_costas_acq_ctrl;
  import costas_ctrl_pkg::*;

  localparam logic [31:0] FS    = 32'h0A3D_70A4;
  localparam logic [31:0] FSTEP = 32'h0006_8DB9;
  localparam logic [31:0] F1    = FS + FSTEP;

  typedef struct packed {
    logic [31:0] cyc;
    logic [2:0]  st;
    logic [31:0] fw;
    logic [5:0]  idx;
    logic        lrst;
    logic        gain;
    logic        lock;
    logic        fl;
  } ev_t;

  typedef struct packed {
    logic [31:0] cyc;
    logic [5:0]  idx;
    logic [31:0] fw;
  } ld_t;

  logic        clk;
  logic        rst;
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_fail = 0;
  ev_t         q_a[$];
  ld_t         q_b[$];
  ev_t         cur_a, prev_a, exp_a;
  ld_t         cur_b, exp_b;
  bit          first_a = 1'b1;
  bit          end_req = 1'b0;
  bit          end_done = 1'b0;

  costas_acq_ctrl_if #(.FW(32)) bus_a ();
  costas_acq_ctrl_if #(.FW(32)) bus_b ();

  costas_acq_ctrl u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  // Shrunk instance so a full 32-point sweep and wrap fits in a short run.
  costas_acq_ctrl #(
    .RST_CYC    (2),
    .SETTLE_SMP (4),
    .WIN_LOG2   (2),
    .LOCK_THR   (1000),
    .ACQ_WIN    (2)
  ) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic ev_t ev(input int unsigned c, input state_e s, input logic [31:0] fw,
                             input int unsigned idx, input logic lr, input logic g,
                             input logic l, input logic fl);
    ev_t e;
    e.cyc = c; e.st = s; e.fw = fw; e.idx = 6'(idx);
    e.lrst = lr; e.gain = g; e.lock = l; e.fl = fl;
    return e;
  endfunction

  function automatic string fmt(input ev_t e);
    return $sformatf("cyc=%0d st=%0d fw=%h idx=%0d lrst=%b gain=%b lock=%b fl=%b",
                     e.cyc, e.st, e.fw, e.idx, e.lrst, e.gain, e.lock, e.fl);
  endfunction

  function automatic logic [44:0] body(input ev_t e);
    return {e.st, e.fw, e.idx, e.lrst, e.gain, e.lock, e.fl};
  endfunction

  task automatic wait_to(input int unsigned t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    cur_a.cyc  = cyc;
    cur_a.st   = bus_a.state_o;
    cur_a.fw   = bus_a.freq_word;
    cur_a.idx  = bus_a.sweep_idx;
    cur_a.lrst = bus_a.loop_rst;
    cur_a.gain = bus_a.gain_sel;
    cur_a.lock = bus_a.locked;
    cur_a.fl   = bus_a.freq_load;
    if (first_a || (body(cur_a) !== body(prev_a))) begin
      n_cmp++;
      if (q_a.size() == 0) begin
        n_fail++;
        $display("FAIL a_unexpected: got %s required no event", fmt(cur_a));
      end else begin
        exp_a = q_a.pop_front();
        if (cur_a !== exp_a) begin
          n_fail++;
          $display("FAIL a_event: got %s required %s", fmt(cur_a), fmt(exp_a));
        end
      end
    end
    first_a = 1'b0;
    prev_a  = cur_a;

    if (bus_b.freq_load === 1'b1) begin
      cur_b.cyc = cyc;
      cur_b.idx = bus_b.sweep_idx;
      cur_b.fw  = bus_b.freq_word;
      n_cmp++;
      if (q_b.size() == 0) begin
        n_fail++;
        $display("FAIL b_unexpected_load: got cyc=%0d idx=%0d fw=%h", cyc, cur_b.idx, cur_b.fw);
      end else begin
        exp_b = q_b.pop_front();
        if (cur_b !== exp_b) begin
          n_fail++;
          $display("FAIL b_sweep_load: got cyc=%0d idx=%0d fw=%h required cyc=%0d idx=%0d fw=%h",
                   cur_b.cyc, cur_b.idx, cur_b.fw, exp_b.cyc, exp_b.idx, exp_b.fw);
        end
      end
    end

    if (end_req && !end_done) begin
      n_cmp++;
      if (q_a.size() != 0) begin
        n_fail++;
        $display("FAIL a_missing: got %0d events outstanding required 0, next %s",
                 q_a.size(), fmt(q_a[0]));
      end
      n_cmp++;
      if (q_b.size() != 0) begin
        n_fail++;
        $display("FAIL b_missing: got %0d loads outstanding required 0", q_b.size());
      end
      end_done = 1'b1;
    end
  end

  initial begin
    rst = 1'b0;
    bus_a.en = 1'b0; bus_a.smp_valid = 1'b1; bus_a.i_arm = 14'sd4000; bus_a.q_arm = 14'sd100;
    bus_b.en = 1'b0; bus_b.smp_valid = 1'b1; bus_b.i_arm = 14'sd2000; bus_b.q_arm = 14'sd2000;

    // Reset, retune, settle, then lock on a strong in-phase arm.
    q_a.push_back(ev(1,    StIdle,   FS, 0, 1, 0, 0, 0));
    q_a.push_back(ev(6,    StLoad,   FS, 0, 1, 0, 0, 1));
    q_a.push_back(ev(7,    StLoad,   FS, 0, 1, 0, 0, 0));
    q_a.push_back(ev(22,   StSettle, FS, 0, 0, 0, 0, 0));
    q_a.push_back(ev(1046, StAcq,    FS, 0, 0, 0, 0, 0));
    q_a.push_back(ev(2071, StTrack,  FS, 0, 0, 1, 1, 0));
    #1 rst = 1'b1;
    wait_to(3);
    rst = 1'b0;
    wait_to(5);
    bus_a.en = 1'b1;

    // Quadrature-dominant arm: lock lost after 8 windows, reload at the same point.
    wait_to(2071);
    bus_a.i_arm = 14'sd100; bus_a.q_arm = 14'sd4000;
    q_a.push_back(ev(4120, StLoad,   FS, 0, 1, 0, 0, 1));
    q_a.push_back(ev(4121, StLoad,   FS, 0, 1, 0, 0, 0));
    q_a.push_back(ev(4136, StSettle, FS, 0, 0, 0, 0, 0));
    q_a.push_back(ev(5160, StAcq,    FS, 0, 0, 0, 0, 0));

    // Zero metric: 16 failed windows then a sweep step.
    wait_to(4136);
    bus_a.i_arm = 14'sd2000; bus_a.q_arm = 14'sd2000;
    q_a.push_back(ev(9257,  StLoad,   F1, 1, 1, 0, 0, 1));
    q_a.push_back(ev(9258,  StLoad,   F1, 1, 1, 0, 0, 0));
    q_a.push_back(ev(9273,  StSettle, F1, 1, 0, 0, 0, 0));
    q_a.push_back(ev(10297, StAcq,    F1, 1, 0, 0, 0, 0));

    // Full-scale negative arm must saturate and pass.
    wait_to(9273);
    bus_a.i_arm = 14'h2000; bus_a.q_arm = 14'sd0;
    q_a.push_back(ev(11322, StTrack, F1, 1, 0, 1, 1, 0));

    // en drop mid-TRACK, mid-ACQ; async reset mid-LOAD.
    q_a.push_back(ev(11401, StIdle,   F1, 1, 1, 0, 0, 0));
    q_a.push_back(ev(11406, StLoad,   F1, 1, 1, 0, 0, 1));
    q_a.push_back(ev(11407, StLoad,   F1, 1, 1, 0, 0, 0));
    q_a.push_back(ev(11422, StSettle, F1, 1, 0, 0, 0, 0));
    q_a.push_back(ev(12446, StAcq,    F1, 1, 0, 0, 0, 0));
    q_a.push_back(ev(12501, StIdle,   F1, 1, 1, 0, 0, 0));
    q_a.push_back(ev(12506, StLoad,   F1, 1, 1, 0, 0, 1));
    q_a.push_back(ev(12507, StLoad,   F1, 1, 1, 0, 0, 0));
    q_a.push_back(ev(12510, StIdle,   FS, 0, 1, 0, 0, 0));
    q_a.push_back(ev(12513, StLoad,   FS, 0, 1, 0, 0, 1));
    q_a.push_back(ev(12514, StLoad,   FS, 0, 1, 0, 0, 0));
    q_a.push_back(ev(12529, StSettle, FS, 0, 0, 0, 0, 0));
    q_a.push_back(ev(12601, StIdle,   FS, 0, 1, 0, 0, 0));
    wait_to(11400);
    bus_a.en = 1'b0;
    wait_to(11405);
    bus_a.en = 1'b1;
    wait_to(12500);
    bus_a.en = 1'b0;
    wait_to(12505);
    bus_a.en = 1'b1;
    wait_to(12510);
    rst = 1'b1;
    wait_to(12512);
    rst = 1'b0;
    wait_to(12600);
    bus_a.en = 1'b0;

    // Shrunk instance: one retune every 15 cycles, index 31 wraps to 0 / F_START.
    for (int k = 0; k <= 32; k++) begin
      ld_t l;
      l.cyc = 32'(13001 + 15 * k);
      l.idx = 6'(k % 32);
      l.fw  = FS + FSTEP * 32'(k % 32);
      q_b.push_back(l);
    end
    wait_to(13000);
    bus_b.en = 1'b1;
    wait_to(13490);
    bus_b.en = 1'b0;
    wait_to(13500);

    end_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
